// File: rtl/uart_pkg.sv
// Shared constants, state encoding and frame-timing helper for the UART
// transmit arbiter.
package uart_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Clock cycles one frame occupies on the line, including trailing guard
    // cycles. One bit lasts (clk_freq/bps)+1 cycles in the transmitter.
    function automatic int uart_frame_cycles(input int clk_freq, input int bps, input int guard);
        return UART_FRAME_BITS * (clk_freq / bps + 1) + guard;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] winner
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    // Rotate the request vector so slot 0 corresponds to the pointer.
    logic [PW-1:0] idx [N];
    logic [N-1:0]  rot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [PW:0] sum;
            assign sum     = {1'b0, ptr} + (PW+1)'(gi);
            assign idx[gi] = (sum >= N_W) ? PW'(sum - N_W) : PW'(sum);
            assign rot[gi] = req[idx[gi]];
        end
    endgenerate

    // Lowest rotated slot wins; scan downward so the last hit is the lowest.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid  = 1'b1;
                winner = idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Issues a one-cycle start pulse with the byte, then holds off further
// grants for an internally timed frame period.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int UART_BPS     = 115200,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int FRAME_CYCLES = uart_frame_cycles(CLK_FREQ, UART_BPS, GUARD_CYCLES);
    localparam int TW = $clog2(FRAME_CYCLES + 1);
    localparam int IW = $clog2(N_REQ);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0] LAST_ID    = IW'(N_REQ - 1);

    arb_state_t       state_reg, state_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [N_REQ-1:0] ack_reg, ack_next;
    logic             tx_start_reg, tx_start_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic [IW-1:0]    grant_id_reg, grant_id_next;
    logic             busy_reg, busy_next;

    logic             win_valid;
    logic [IW-1:0]    win_idx;
    logic [7:0]       req_bytes [N_REQ];
    logic             grant;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(.N(N_REQ), .PW(IW)) u_rr (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (win_valid),
        .winner (win_idx)
    );

    assign grant = (state_reg == ST_IDLE) && en && win_valid;

    // State and datapath registers; reset clears everything including the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            timer_reg    <= '0;
            ack_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            grant_id_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            timer_reg    <= timer_next;
            ack_reg      <= ack_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
            grant_id_reg <= grant_id_next;
            busy_reg     <= busy_next;
        end
    end

    // Next state: grant moves to BUSY, expired frame timer returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant) state_next = ST_BUSY;
            ST_BUSY: if (timer_reg == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything holds unless updated here.
    always_comb begin
        ptr_next      = ptr_reg;
        timer_next    = timer_reg;
        ack_next      = ack_reg;
        tx_start_next = tx_start_reg;
        tx_data_next  = tx_data_reg;
        grant_id_next = grant_id_reg;
        busy_next     = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    tx_data_next  = req_bytes[win_idx];
                    tx_start_next = 1'b1;
                    ack_next      = N_REQ'(1) << win_idx;
                    grant_id_next = win_idx;
                    busy_next     = 1'b1;
                    timer_next    = TIMER_LOAD;
                end
            end
            ST_BUSY: begin
                tx_start_next = 1'b0;
                ack_next      = '0;
                if (timer_reg == '0) begin
                    busy_next = 1'b0;
                    ptr_next  = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ack      = ack_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic, checked by
// a grant-level reference model feeding a scoreboard queue.
module tb_uart_tx_arb;

    localparam int FRAME = 114;   // 10*(1_000_000/100_000+1)+4

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;

    uart_tx_arb #(
        .N_REQ(4), .CLK_FREQ(1_000_000), .UART_BPS(100_000), .GUARD_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         edge_n;
        int         w;
        logic [7:0] d;
    } grant_t;

    grant_t     exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         edge_cnt = 0;
    int         n_exp = 0;
    int         n_seen = 0;

    // Reference model state: expressed as "when is the line free again".
    int         m_ptr = 0;
    int         m_free = 0;
    bit         m_have = 0;
    int         m_gedge = 0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_gid = 2'd0;

    logic [3:0] keep;

    function automatic int rr_pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, expv);
        end
    endtask

    // Model: at each edge decide whether a grant happens and whom it goes to.
    initial begin
        forever begin
            int now;
            int w;
            grant_t g;
            @(posedge clk);
            now = edge_cnt;
            if (rst) begin
                m_ptr  = 0;
                m_free = now + 1;
                m_have = 0;
                m_data = 8'h00;
                m_gid  = 2'd0;
                exp_q.delete();
            end else if (now >= m_free && en && (|req)) begin
                w        = rr_pick(req, m_ptr);
                g.edge_n = now;
                g.w      = w;
                g.d      = req_data[8*w +: 8];
                exp_q.push_back(g);
                n_exp++;
                m_ptr   = (w + 1) % 4;
                m_free  = now + FRAME + 1;
                m_have  = 1;
                m_gedge = now;
                m_data  = g.d;
                m_gid   = 2'(w);
            end
            edge_cnt++;
        end
    end

    // Monitor: compare registered outputs each cycle, pop on every start pulse.
    initial begin
        forever begin
            int now;
            logic exp_busy;
            grant_t g;
            @(negedge clk);
            now = edge_cnt - 1;
            if (now >= 0) begin
                exp_busy = m_have && ((now - m_gedge) <= FRAME - 1);
                check("busy_data_gid", {21'd0, busy, tx_data, grant_id},
                      {21'd0, exp_busy, m_data, m_gid});
                if (tx_start) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_start t=%0t actual=tx_start=1 required=no_start", $time);
                    end else begin
                        g = exp_q.pop_front();
                        n_seen++;
                        check("start_edge", now, g.edge_n);
                        check("ack", {28'd0, ack}, 32'd1 << g.w);
                        check("tx_data_at_start", {24'd0, tx_data}, {24'd0, g.d});
                        $display("grant edge=%0d id=%0d data=%h", now, grant_id, tx_data);
                    end
                end else begin
                    check("ack_without_start", {28'd0, ack}, 32'd0);
                    if (exp_q.size() > 0 && exp_q[0].edge_n < now) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_start t=%0t actual=no_start required=start_at_edge_%0d",
                                 $time, exp_q[0].edge_n);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Advance n cycles; requesters react to their ack (drop, or keep with next byte).
    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if (keep[i]) req_data[8*i +: 8] = req_data[8*i +: 8] + 8'd1;
                    else         req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic quiesce();
        en = 1'b0;
        tick(FRAME + 10);
        req  = 4'b0000;
        keep = 4'b0000;
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'b0; req_data = 32'h0; keep = 4'b0;
        tick(3);
        rst = 1'b0;
        en  = 1'b1;
        tick(2);

        // Single request to requester 2.
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick(FRAME + 10);

        // Round robin from a reset pointer, all four held.
        do_reset();
        req_data = 32'h44332211;
        keep = 4'b1111;
        req  = 4'b1111;
        tick(5 * (FRAME + 1) + 5);
        quiesce();

        // Pointer wrap: grant 3, then 0 and 3 compete.
        do_reset();
        en = 1'b1;
        req_data = 32'hC3000000;
        req = 4'b1000;
        tick(2);
        req_data[7:0]   = 8'h3C;
        req_data[31:24] = 8'hD4;
        req = 4'b1001;
        tick(3 * (FRAME + 1) + 5);

        // en gating: no grant while low, grant once raised, frame finishes after drop.
        en = 1'b0;
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        tick(300);
        en = 1'b1;
        tick(50);
        en = 1'b0;
        req = 4'b0001;
        tick(FRAME + 60);
        req = 4'b0000;
        tick(2);

        // Reset in the middle of a frame.
        en = 1'b1;
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req_data[15:8]  = 8'hB1;
        req_data[31:24] = 8'hB3;
        req = 4'b1010;
        tick(2 * (FRAME + 1) + 5);

        // Back-to-back single requester with changing data.
        req_data[7:0] = 8'h01;
        keep = 4'b0001;
        req  = 4'b0001;
        tick(FRAME + 10);
        quiesce();

        // Random traffic.
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            en = ($urandom_range(15) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(7) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    keep[i] = 1'($urandom_range(1));
                    req[i]  = 1'b1;
                end
            end
        end
        quiesce();
        tick(5);

        check("queue_drained", exp_q.size(), 32'd0);
        check("grant_count", n_seen, n_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one uart_tx transmitter among N byte requesters using round-robin arbitration.
- Issues a one-cycle start pulse plus a byte to the transmitter, then holds off further grants until the frame has completed.
- Sits between the application or loopback sources and the uart_tx start/data inputs.
- Frame completion is timed internally, because the transmitter exposes no busy flag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLK_FREQ, 50_000_000, system clock in Hz.
- UART_BPS, 115200, baud rate.
- GUARD_CYCLES, 4, extra idle cycles appended to each frame. Covers the transmitter's 2-cycle start-edge latency plus margin.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- en  input  1  when low, no new grant is issued; a frame already in flight completes.
- req  input  N_REQ  level request per requester. Must be held, with its data stable, until the matching ack.
- req_data  input  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i].
- ack  output  N_REQ  one-hot, one-cycle pulse: request i has been accepted.
- tx_start  output  1  one-cycle pulse to the transmitter's start input.
- tx_data  output  8  byte to the transmitter; held stable for the whole frame.
- grant_id  output  $clog2(N_REQ)  index of the last granted requester.
- busy  output  1  high while a frame is in flight.

Behaviour:
Constants:
- BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
- BIT_CYCLES = BAUD_CNT_MAX+1.
- FRAME_CYCLES = 10*BIT_CYCLES + GUARD_CYCLES.
- Timer width = $clog2(FRAME_CYCLES+1).

Reset values (all outputs registered):
- ack=0, tx_start=0, tx_data=0, grant_id=0, busy=0.
- State=IDLE, rr pointer=0, timer=0.

States:
- IDLE:
  - If en && |req, pick the winner w: the first set req[i] scanning from the pointer upward, wrapping modulo N_REQ.
  - At the clock edge: tx_data<=req_data[w], tx_start<=1, ack<=1<<w, grant_id<=w, busy<=1, timer<=FRAME_CYCLES-1, state->BUSY.
  - Otherwise remain in IDLE with all outputs holding.
- BUSY:
  - tx_start and ack are high only in the first BUSY cycle; they are cleared on the following edge.
  - Timer decrements by 1 each cycle.
  - When the timer is 0: state->IDLE, busy<=0, pointer<=(grant_id+1) mod N_REQ.
  - req changes are ignored in BUSY.

Timing:
- Request-to-start latency: 1 cycle; ack is coincident with tx_start.
- The BUSY state lasts exactly FRAME_CYCLES cycles.
- Minimum spacing between tx_start pulses: FRAME_CYCLES+1 cycles, because there is always one IDLE cycle between frames.

Boundary conditions:
- A single requester held continuously is granted every FRAME_CYCLES+1 cycles.
- Requesters are never starved: each waits at most N_REQ-1 frames.
- en dropped during BUSY: the current frame completes, then the block stays in IDLE.
- en dropped in the same cycle as a req arrives: no grant.
- rst mid-frame: everything returns to reset values on the next edge. tx_start is never asserted during reset, and the rr pointer returns to 0.
- req dropped before ack: permitted only while IDLE with en low; otherwise it is a protocol violation with no guaranteed behaviour.
- tx_data changes only on a grant edge.

Decomposition:
- Package uart_pkg holds:
  - function uart_frame_cycles(clk_freq, bps, guard);
  - state encoding constants ST_IDLE and ST_BUSY;
  - constant UART_FRAME_BITS=10.
- Sub-module rr_arbiter:
  - combinational round-robin pick;
  - inputs: req[N], ptr;
  - outputs: valid, winner index.

Test Plan:
All scenarios use the sim parameters N_REQ=4, CLK_FREQ=1_000_000, UART_BPS=100_000, GUARD_CYCLES=4. This gives BIT_CYCLES=11 and FRAME_CYCLES=114.
- Single request: req=4'b0100, req_data[23:16]=8'hA5 at cycle 0.
  - Cycle 1: tx_start=1, ack=4'b0100, tx_data=8'hA5, grant_id=2.
  - busy is high for 114 cycles.
  - Decoded uart_txd frame: start bit, 0xA5 LSB-first, stop bit.
- Round-robin: all four req held with bytes 0x11/0x22/0x33/0x44.
  - Grants occur in order 0,1,2,3,0, with tx_start pulses exactly 115 cycles apart.
  - Bytes appear in that order on uart_txd.
- Pointer wrap: grant requester 3, then raise req=4'b1001.
  - The next grant goes to 0, then 3.
- en gating: en=0 with req=4'b0001 for 300 cycles gives no tx_start and no ack.
  - Raising en produces a grant 1 cycle later.
  - Lowering en mid-frame still lets busy complete at 114 cycles, with no further grant.
- Reset mid-frame: assert rst at BUSY cycle 50.
  - Next edge: busy=0, tx_data=0, ack=0, grant_id=0.
  - After release with req=4'b0010, the grant goes to 1 (pointer was reset to 0).
- Back-to-back single requester: req[0] held with data changing 0x01->0x02 after each ack.
  - Two frames, bytes 0x01 then 0x02, with tx_start pulses 115 cycles apart.
